ps2_key_decoder: RTL and testbench

- Consumes the raw scan-code byte stream from the PS/2 receiver stage (one strobe per validated frame) and produces decoded key events.
- Resolves Set-2 prefixes (E0 extended, F0 break), detects typematic repeats, maps common keys to ASCII, and buffers events in a FIFO.
- The CPU-side peripheral drains the FIFO through a valid/ready interface.

---
 rtl/ps2_key_decoder_if.sv | 37 +++
 rtl/ps2_key_decoder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// Scan-code byte stream in, decoded key events out (valid/ready).
// master = decoder side, slave = surrounding receiver/consumer side.
interface ps2_key_decoder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_release;
    logic       out_repeat;
    logic [7:0] out_ascii;

    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_code,
        output out_ext,
        output out_release,
        output out_repeat,
        output out_ascii
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_code,
        input  out_ext,
        input  out_release,
        input  out_repeat,
        input  out_ascii
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: prefix FSM, held-key tracker,
// ASCII map and a fall-through event FIFO.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_decoder_if.master bus,
    output logic             overflow,
    output logic             proto_err,
    output logic             held,
    output logic [CNT_W-1:0] press_count
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       rep;
        logic [7:0] ascii;
    } evt_t;

    function automatic logic [7:0] to_ascii(input logic [7:0] c);
        logic [7:0] a;
        a = 8'h00;
        case (c)
            8'h1C: a = "a";
            8'h32: a = "b";
            8'h21: a = "c";
            8'h23: a = "d";
            8'h24: a = "e";
            8'h2B: a = "f";
            8'h34: a = "g";
            8'h33: a = "h";
            8'h43: a = "i";
            8'h3B: a = "j";
            8'h42: a = "k";
            8'h4B: a = "l";
            8'h3A: a = "m";
            8'h31: a = "n";
            8'h44: a = "o";
            8'h4D: a = "p";
            8'h15: a = "q";
            8'h2D: a = "r";
            8'h1B: a = "s";
            8'h2C: a = "t";
            8'h3C: a = "u";
            8'h2A: a = "v";
            8'h1D: a = "w";
            8'h22: a = "x";
            8'h35: a = "y";
            8'h1A: a = "z";
            8'h45: a = "0";
            8'h16: a = "1";
            8'h1E: a = "2";
            8'h26: a = "3";
            8'h25: a = "4";
            8'h2E: a = "5";
            8'h36: a = "6";
            8'h3D: a = "7";
            8'h3E: a = "8";
            8'h46: a = "9";
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    state_t state;
    state_t state_nxt;

    logic is_e0;
    logic is_f0;
    logic is_pfx;
    logic is_junk;

    assign is_e0   = bus.in_data == 8'hE0;
    assign is_f0   = bus.in_data == 8'hF0;
    assign is_pfx  = is_e0 || is_f0;
    assign is_junk = (bus.in_data == 8'h00) || (bus.in_data == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.in_valid) begin
            if (is_junk) begin
                state_nxt = IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (is_e0)      state_nxt = EXT;
                        else if (is_f0) state_nxt = BRK;
                        else            state_nxt = IDLE;
                    end
                    EXT: begin
                        if (is_f0)      state_nxt = EXT_BRK;
                        else if (is_e0) state_nxt = EXT;
                        else            state_nxt = IDLE;
                    end
                    BRK:     state_nxt = IDLE;
                    EXT_BRK: state_nxt = IDLE;
                endcase
            end
        end
    end

    logic emit;
    logic ev_ext;
    logic ev_rel;
    logic seq_err;

    always_comb begin
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_rel  = 1'b0;
        seq_err = 1'b0;
        if (bus.in_valid && !is_junk) begin
            unique case (state)
                IDLE: begin
                    emit = !is_pfx;
                end
                EXT: begin
                    emit   = !is_pfx;
                    ev_ext = 1'b1;
                end
                BRK: begin
                    emit    = !is_pfx;
                    ev_rel  = 1'b1;
                    seq_err = is_pfx;
                end
                EXT_BRK: begin
                    emit    = !is_pfx;
                    ev_ext  = 1'b1;
                    ev_rel  = 1'b1;
                    seq_err = is_pfx;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else begin
            proto_err <= seq_err;
        end
    end

    logic [7:0] held_code;
    logic       held_ext;
    logic       same_key;

    assign same_key = held
                   && (held_code == bus.in_data)
                   && (held_ext == ev_ext);

    // Tracker follows the key stream even when the FIFO drops the event.
    always_ff @(posedge clk) begin
        if (rst) begin
            held        <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            press_count <= '0;
        end else if (emit) begin
            if (!ev_rel) begin
                if (!same_key) begin
                    held        <= 1'b1;
                    held_code   <= bus.in_data;
                    held_ext    <= ev_ext;
                    press_count <= press_count + 1'b1;
                end
            end else if (same_key) begin
                held <= 1'b0;
            end
        end
    end

    evt_t ev;

    always_comb begin
        ev.code  = bus.in_data;
        ev.ext   = ev_ext;
        ev.rel   = ev_rel;
        ev.rep   = !ev_rel && same_key;
        ev.ascii = ev_ext ? 8'h00 : to_ascii(bus.in_data);
    end

    evt_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full    = count == FULL_CNT;
    assign pop     = bus.out_valid && bus.out_ready;
    assign push_ok = emit && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (emit && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    evt_t head;

    assign head            = mem[rd_ptr];
    assign bus.out_valid   = count != '0;
    assign bus.out_code    = head.code;
    assign bus.out_ext     = head.ext;
    assign bus.out_release = head.rel;
    assign bus.out_repeat  = head.rep;
    assign bus.out_ascii   = head.ascii;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: prefixes, repeats, ASCII,
// FIFO overflow/fall-through, protocol errors and reset.
module tb_ps2_key_decoder;

    logic       clk;
    logic       rst;
    logic       overflow;
    logic       proto_err;
    logic       held;
    logic [7:0] press_count;

    int checks;
    int errors;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FIFO_DEPTH(8),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .overflow   (overflow),
        .proto_err  (proto_err),
        .held       (held),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic pop_evt(input string tag,
                           input logic [7:0] c,
                           input logic e,
                           input logic r,
                           input logic p,
                           input logic [7:0] a);
        check({tag, "_v"}, 32'(bus.out_valid), 32'd1);
        check(tag,
              32'({bus.out_code, bus.out_ext, bus.out_release,
                   bus.out_repeat, bus.out_ascii}),
              32'({c, e, r, p, a}));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    logic [7:0] codes [9];
    logic [7:0] ascs  [9];

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                  8'h36, 8'h3D, 8'h3E, 8'h46};
        ascs  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                  8'h36, 8'h37, 8'h38, 8'h39};

        do_reset();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        check("rst_cnt", 32'(press_count), 32'd0);

        // make/break of 'a'
        send(8'h1C);
        check("a_held", 32'(held), 32'd1);
        send(8'hF0);
        send(8'h1C);
        check("a_rel_held", 32'(held), 32'd0);
        check("a_cnt", 32'(press_count), 32'd1);
        pop_evt("a_make", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        pop_evt("a_brk", 8'h1C, 1'b0, 1'b1, 1'b0, 8'h61);
        check("a_empty", 32'(bus.out_valid), 32'd0);

        // extended key
        send(8'hE0);
        send(8'h75);
        check("x_held", 32'(held), 32'd1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("x_rel_held", 32'(held), 32'd0);
        pop_evt("x_make", 8'h75, 1'b1, 1'b0, 1'b0, 8'h00);
        pop_evt("x_brk", 8'h75, 1'b1, 1'b1, 1'b0, 8'h00);

        // typematic repeat
        do_reset();
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        check("rp_cnt", 32'(press_count), 32'd1);
        pop_evt("rp0", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        pop_evt("rp1", 8'h1C, 1'b0, 1'b0, 1'b1, 8'h61);
        pop_evt("rp2", 8'h1C, 1'b0, 1'b0, 1'b1, 8'h61);
        pop_evt("rp_brk", 8'h1C, 1'b0, 1'b1, 1'b0, 8'h61);
        send(8'h32);
        send(8'h32);
        check("b_cnt", 32'(press_count), 32'd2);
        pop_evt("b_make", 8'h32, 1'b0, 1'b0, 1'b0, 8'h62);
        pop_evt("b_rep", 8'h32, 1'b0, 1'b0, 1'b1, 8'h62);
        // non-matching break leaves b held
        send(8'hF0);
        send(8'h1C);
        check("nm_held", 32'(held), 32'd1);
        pop_evt("nm_brk", 8'h1C, 1'b0, 1'b1, 1'b0, 8'h61);

        // overflow with 9 pushes into 8 entries
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(codes[i]);
            if (i == 7) check("ovf_pre", 32'(overflow), 32'd0);
        end
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(bus.out_code), 32'h16);
        @(posedge clk);
        #1 check("ovf_stable", 32'(bus.out_code), 32'h16);
        // pop and push in the same cycle while full
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h45;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 1; i < 8; i++) begin
            pop_evt($sformatf("ovf_q%0d", i),
                    codes[i], 1'b0, 1'b0, 1'b0, ascs[i]);
        end
        pop_evt("ovf_last", 8'h45, 1'b0, 1'b0, 1'b0, 8'h30);
        check("ovf_empty", 32'(bus.out_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // protocol errors and junk bytes
        do_reset();
        send(8'hF0);
        send(8'hF0);
        check("pe_pulse", 32'(proto_err), 32'd1);
        @(posedge clk);
        #1 check("pe_clear", 32'(proto_err), 32'd0);
        check("pe_noevt", 32'(bus.out_valid), 32'd0);
        send(8'h16);
        pop_evt("pe_one", 8'h16, 1'b0, 1'b0, 1'b0, 8'h31);
        send(8'hE0);
        send(8'hF0);
        send(8'hE0);
        check("pe_ext", 32'(proto_err), 32'd1);
        send(8'hE0);
        send(8'hFF);
        check("ff_noerr", 32'(proto_err), 32'd0);
        send(8'h1C);
        pop_evt("ff_a", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        check("ff_empty", 32'(bus.out_valid), 32'd0);
        send(8'h29);
        pop_evt("space", 8'h29, 1'b0, 1'b0, 1'b0, 8'h20);

        // reset with queued events and FSM in EXT
        do_reset();
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'hE0);
        check("mr_pre", 32'(press_count), 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mr_valid", 32'(bus.out_valid), 32'd0);
        check("mr_held", 32'(held), 32'd0);
        check("mr_cnt", 32'(press_count), 32'd0);
        send(8'h5A);
        pop_evt("mr_enter", 8'h5A, 1'b0, 1'b0, 1'b0, 8'h0D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
